fetch_redirect_ctrl: RTL

Sequences redirection of the 2-wide fetch unit. It arbitrates two redirect requesters: exception/interrupt, which has higher priority, and branch resolve. For the accepted request it drives the fetch exception controls in a fixed order: EVENT, then DISCARD while in-flight fetches drain, then ADDR_SET+RESTART. Sits between the execute/exception stage and the fetch unit, and tracks the number of outstanding memory fetches.

---
 rtl/fetch_redirect_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Redirect sequencer for the 2-wide fetch unit: arbitrates exception and branch
// redirects and walks fetch through EVENT -> DISCARD (drain) -> ADDR_SET+RESTART.
module fetch_redirect_ctrl #(
    parameter int unsigned P_MAX_OUTSTANDING = 8,
    parameter int unsigned P_CNT_W           = 4
) (
    input  logic               iCLOCK,
    input  logic               iRESET_SYNC,
    input  logic               iEXC_REQ,
    input  logic [31:0]        iEXC_ADDR,
    output logic               oEXC_ACK,
    input  logic               iBR_REQ,
    input  logic [31:0]        iBR_ADDR,
    output logic               oBR_ACK,
    input  logic               iFETCH_ISSUE,
    input  logic               iFETCH_RETURN,
    output logic               oEXCEPTION_EVENT,
    output logic               oEXCEPTION_INST_DISCARD,
    output logic               oEXCEPTION_ADDR_SET,
    output logic [31:0]        oEXCEPTION_ADDR,
    output logic               oEXCEPTION_RESTART,
    output logic               oBUSY,
    output logic [P_CNT_W-1:0] oOUTSTANDING,
    output logic               oCNT_ERR
);

    localparam logic [P_CNT_W-1:0] L_CNT_MAX = P_CNT_W'(P_MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FLUSH   = 2'd1,
        S_DRAIN   = 2'd2,
        S_RESTART = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [P_CNT_W-1:0]   r_cnt;
    logic [P_CNT_W-1:0]   w_cnt_next;
    logic                 r_cnt_err;
    logic [31:0]          r_addr;
    logic                 r_event;
    logic                 r_discard;
    logic                 r_restart;
    logic                 r_busy;
    logic                 w_exc_ack;
    logic                 w_br_ack;
    logic                 w_inc;
    logic                 w_dec;
    logic                 w_cnt_fault;

    // Acks are gated by reset so nothing is accepted on a reset edge
    assign w_exc_ack = iEXC_REQ && !iRESET_SYNC;
    assign w_br_ack  = iBR_REQ && !iEXC_REQ && !iRESET_SYNC && (r_state == S_IDLE);

    // Outstanding-fetch counter: saturate at both ends and flag the attempt
    always_comb begin
        w_inc       = iFETCH_ISSUE && !iFETCH_RETURN;
        w_dec       = iFETCH_RETURN && !iFETCH_ISSUE;
        w_cnt_next  = r_cnt;
        w_cnt_fault = 1'b0;
        if (w_inc) begin
            if (r_cnt == L_CNT_MAX) begin
                w_cnt_fault = 1'b1;
            end else begin
                w_cnt_next = r_cnt + P_CNT_W'(1);
            end
        end else if (w_dec) begin
            if (r_cnt == '0) begin
                w_cnt_fault = 1'b1;
            end else begin
                w_cnt_next = r_cnt - P_CNT_W'(1);
            end
        end
    end

    // Next state; an accepted exception restarts the sequence from any state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_br_ack) w_state_next = S_FLUSH;
            S_FLUSH:   w_state_next = S_DRAIN;
            S_DRAIN:   if (w_cnt_next == '0) w_state_next = S_RESTART;
            S_RESTART: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
        if (w_exc_ack) begin
            w_state_next = S_FLUSH;
        end
    end

    // Strobes are registered from the next state so each is a clean flop output
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cnt_err <= 1'b0;
            r_addr    <= 32'd0;
            r_event   <= 1'b0;
            r_discard <= 1'b0;
            r_restart <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_cnt_err <= r_cnt_err || w_cnt_fault;
            if (w_exc_ack) begin
                r_addr <= iEXC_ADDR;
            end else if (w_br_ack) begin
                r_addr <= iBR_ADDR;
            end
            r_event   <= (w_state_next == S_FLUSH);
            r_discard <= (w_state_next == S_DRAIN);
            r_restart <= (w_state_next == S_RESTART);
            r_busy    <= (w_state_next != S_IDLE);
        end
    end

    assign oEXC_ACK                = w_exc_ack;
    assign oBR_ACK                 = w_br_ack;
    assign oEXCEPTION_EVENT        = r_event;
    assign oEXCEPTION_INST_DISCARD = r_discard;
    assign oEXCEPTION_ADDR_SET     = r_restart;
    assign oEXCEPTION_RESTART      = r_restart;
    assign oEXCEPTION_ADDR         = r_addr;
    assign oBUSY                   = r_busy;
    assign oOUTSTANDING            = r_cnt;
    assign oCNT_ERR                = r_cnt_err;

endmodule
